// File: rtl/signed_accum_unit_if.sv
// signed_accum_unit_if
// Handshake and data bundle between an upstream operand source, the signed
// accumulator and the downstream result consumer. The master modport is the
// environment side; the slave modport is the accumulator itself.
interface signed_accum_unit_if #(
  parameter int WIDTH   = 32,
  parameter int COUNT_W = 8
);

  // Frame control
  logic               start;
  logic [COUNT_W-1:0] len;
  logic               busy;

  // Operand stream (valid/ready)
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   num_in;

  // Result (valid/ready)
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   acc_sum;
  logic               ovf;

  modport master (
    output start,
    output len,
    output in_valid,
    output num_in,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  acc_sum,
    input  ovf,
    input  busy
  );

  modport slave (
    input  start,
    input  len,
    input  in_valid,
    input  num_in,
    input  out_ready,
    output in_ready,
    output out_valid,
    output acc_sum,
    output ovf,
    output busy
  );

endinterface

// File: rtl/signed_accum_unit.sv
// signed_accum_unit
// Frame-based signed accumulator. A start pulse in IDLE programs the frame
// length; each accepted operand is added to the running two's-complement sum
// and a sticky flag records any signed overflow. The frame total is offered
// on a valid/ready result port and held until the consumer takes it.
//
// Optional feature macro: SIGNED_ACCUM_SAT_EN
//   defined   - an overflowing addition clamps to the most positive or most
//               negative representable value and accumulation continues from
//               the clamped value.
//   undefined - additions wrap modulo 2^WIDTH.
// In both builds the overflow flag is set on an overflowing transfer.
//
// All outputs come straight from flops. The handshake flags are computed
// from the next state so that they line up with the state register.
module signed_accum_unit #(
  parameter int WIDTH   = 32,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  signed_accum_unit_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ACCUM = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  localparam logic [WIDTH-1:0]   SUM_ZERO = {WIDTH{1'b0}};
  localparam logic [COUNT_W-1:0] CNT_ZERO = {COUNT_W{1'b0}};
  localparam logic [COUNT_W-1:0] CNT_ONE  = {{(COUNT_W-1){1'b0}}, 1'b1};

`ifdef SIGNED_ACCUM_SAT_EN
  localparam logic [WIDTH-1:0]   SUM_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]   SUM_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

  // Clamp value for an overflowing add. Overflow can only happen when both
  // operands share a sign, so the sign of the old sum picks the rail.
  function automatic logic [WIDTH-1:0] sat_limit(input logic neg_operands);
    if (neg_operands) begin
      sat_limit = SUM_MIN;
    end else begin
      sat_limit = SUM_MAX;
    end
  endfunction
`endif

  // Signed overflow of a + b = s: operands agree in sign, result does not.
  function automatic logic add_overflows(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [WIDTH-1:0] s
  );
    add_overflows = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
  endfunction

  // Registered state
  state_t             state_r;
  logic [WIDTH-1:0]   acc_r;
  logic               ovf_r;
  logic [COUNT_W-1:0] count_r;
  logic [COUNT_W-1:0] len_r;
  logic               in_ready_r;
  logic               out_valid_r;
  logic               busy_r;

  // Next-state values
  state_t             state_s;
  logic [WIDTH-1:0]   acc_s;
  logic               ovf_s;
  logic [COUNT_W-1:0] count_s;
  logic [COUNT_W-1:0] len_s;

  // Datapath for one transfer
  logic [WIDTH-1:0]   raw_sum_s;
  logic               step_ovf_s;
  logic [WIDTH-1:0]   step_sum_s;
  logic               xfer_s;
  logic               last_xfer_s;

  // Operand add, overflow detection and optional clamping for this cycle
  always_comb begin
    raw_sum_s  = acc_r + bus.num_in;
    step_ovf_s = add_overflows(acc_r, bus.num_in, raw_sum_s);
`ifdef SIGNED_ACCUM_SAT_EN
    if (step_ovf_s) begin
      step_sum_s = sat_limit(acc_r[WIDTH-1]);
    end else begin
      step_sum_s = raw_sum_s;
    end
`else
    step_sum_s = raw_sum_s;
`endif
  end

  // Transfer qualification: ready is only ever high while accumulating
  always_comb begin
    xfer_s      = bus.in_valid && in_ready_r;
    last_xfer_s = (count_r == (len_r - CNT_ONE));
  end

  // Next-state and datapath update decisions
  always_comb begin
    state_s = state_r;
    acc_s   = acc_r;
    ovf_s   = ovf_r;
    count_s = count_r;
    len_s   = len_r;

    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          acc_s   = SUM_ZERO;
          ovf_s   = 1'b0;
          count_s = CNT_ZERO;
          len_s   = bus.len;
          if (bus.len == CNT_ZERO) begin
            // Empty frame: report a zero total straight away
            state_s = ST_DONE;
          end else begin
            state_s = ST_ACCUM;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_ACCUM: begin
        if (xfer_s) begin
          acc_s   = step_sum_s;
          ovf_s   = ovf_r | step_ovf_s;
          count_s = count_r + CNT_ONE;
          if (last_xfer_s) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_ACCUM;
          end
        end else begin
          // Upstream stall: hold everything
          state_s = ST_ACCUM;
        end
      end

      ST_DONE: begin
        // Result and flag stay frozen; a coincident start is deliberately
        // not looked at here and must be re-issued once back in IDLE.
        if (bus.out_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and output flops; reset aborts any frame in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      acc_r       <= SUM_ZERO;
      ovf_r       <= 1'b0;
      count_r     <= CNT_ZERO;
      len_r       <= CNT_ZERO;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      acc_r       <= acc_s;
      ovf_r       <= ovf_s;
      count_r     <= count_s;
      len_r       <= len_s;
      in_ready_r  <= (state_s == ST_ACCUM);
      out_valid_r <= (state_s == ST_DONE);
      busy_r      <= (state_s != ST_IDLE);
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.acc_sum   = acc_r;
  assign bus.ovf       = ovf_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_signed_accum_unit.sv
// tb_signed_accum_unit
// Directed bench for signed_accum_unit. A frame-level reference model tracks
// what the block must show (phase of the frame, running sum computed with
// wide integer arithmetic, sticky overflow) and a single monitor compares
// every output against it each cycle, plus hand-computed literal totals for
// each frame. Build with +define+SIGNED_ACCUM_SAT_EN for the clamping variant.
module tb_signed_accum_unit;

  localparam int PH_IDLE  = 0;
  localparam int PH_ACCUM = 1;
  localparam int PH_DONE  = 2;

  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic clk;
  logic rst_n;

  signed_accum_unit_if #(.WIDTH(32), .COUNT_W(8)) bus ();

  signed_accum_unit #(.WIDTH(32), .COUNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Counters (written only by the monitor)
  int n_tests = 0;
  int n_fail  = 0;

  // Written only by the stimulus
  int          timeout_cnt = 0;
  logic        lit_armed;
  logic [31:0] lit_sum;
  logic        lit_ovf;

  // Reference model state
  int          m_phase = PH_IDLE;
  int          m_left  = 0;
  logic [31:0] m_sum   = 32'h0;
  logic        m_ovf   = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint wide_sum(input logic [31:0] a, input logic [31:0] b);
    return longint'($signed(a)) + longint'($signed(b));
  endfunction

  function automatic logic model_ovf(input logic [31:0] a, input logic [31:0] b);
    longint s;
    s = wide_sum(a, b);
    return (s > MAXV) || (s < MINV);
  endfunction

  function automatic logic [31:0] model_sum(input logic [31:0] a, input logic [31:0] b);
    longint s;
    s = wide_sum(a, b);
`ifdef SIGNED_ACCUM_SAT_EN
    if (s > MAXV) return 32'h7FFF_FFFF;
    if (s < MINV) return 32'h8000_0000;
`endif
    return s[31:0];
  endfunction

  // Reference model: frame-level behaviour in terms of operands seen
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= PH_IDLE;
      m_sum   <= 32'h0;
      m_ovf   <= 1'b0;
      m_left  <= 0;
    end else begin
      case (m_phase)
        PH_IDLE: begin
          if (bus.start) begin
            m_sum   <= 32'h0;
            m_ovf   <= 1'b0;
            m_left  <= int'(bus.len);
            m_phase <= (bus.len == 8'd0) ? PH_DONE : PH_ACCUM;
          end
        end
        PH_ACCUM: begin
          if (bus.in_valid) begin
            m_sum  <= model_sum(m_sum, bus.num_in);
            m_ovf  <= m_ovf | model_ovf(m_sum, bus.num_in);
            m_left <= m_left - 1;
            if (m_left == 1) m_phase <= PH_DONE;
          end
        end
        PH_DONE: begin
          if (bus.out_ready) m_phase <= PH_IDLE;
        end
        default: m_phase <= PH_IDLE;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every output against the model each cycle and on reset
  always begin
    @(negedge clk or negedge rst_n);
    #1;
    if (!rst_n) begin
      check("rst_acc_sum",   bus.acc_sum, 32'h0);
      check("rst_ovf",       {31'h0, bus.ovf}, 32'h0);
      check("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
      check("rst_in_ready",  {31'h0, bus.in_ready}, 32'h0);
      check("rst_busy",      {31'h0, bus.busy}, 32'h0);
    end else begin
      check("timeouts",  32'(timeout_cnt), 32'h0);
      check("busy",      {31'h0, bus.busy},      {31'h0, (m_phase != PH_IDLE)});
      check("in_ready",  {31'h0, bus.in_ready},  {31'h0, (m_phase == PH_ACCUM)});
      check("out_valid", {31'h0, bus.out_valid}, {31'h0, (m_phase == PH_DONE)});
      if (m_phase != PH_IDLE) begin
        check("acc_sum", bus.acc_sum, m_sum);
        check("ovf",     {31'h0, bus.ovf}, {31'h0, m_ovf});
      end
      if (lit_armed && (m_phase == PH_DONE)) begin
        check("lit_sum",   bus.acc_sum, lit_sum);
        check("lit_ovf",   {31'h0, bus.ovf}, {31'h0, lit_ovf});
        check("model_sum", m_sum, lit_sum);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [7:0] l);
    bus.start = 1'b1;
    bus.len   = l;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send(input logic [31:0] op, input int gap);
    int waited;
    bus.in_valid = 1'b0;
    repeat (gap) tick();
    bus.in_valid = 1'b1;
    bus.num_in   = op;
    waited = 0;
    while (!bus.in_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (waited >= 20) timeout_cnt++;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid;
    int waited;
    waited = 0;
    while (!bus.out_valid && waited < 20) begin
      tick();
      waited++;
    end
    if (waited >= 20) timeout_cnt++;
  endtask

  task automatic finish_frame(input int hold);
    wait_valid();
    bus.out_ready = 1'b0;
    repeat (hold) tick();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    lit_armed = 1'b0;
    tick();
  endtask

  task automatic run_pair(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_sum, input logic exp_ovf);
    lit_sum   = exp_sum;
    lit_ovf   = exp_ovf;
    lit_armed = 1'b1;
    start_frame(8'd2);
    send(a, 0);
    send(b, 0);
    finish_frame(0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.len       = 8'd0;
    bus.in_valid  = 1'b0;
    bus.num_in    = 32'h0;
    bus.out_ready = 1'b0;
    lit_armed     = 1'b0;
    lit_sum       = 32'h0;
    lit_ovf       = 1'b0;

    #22 rst_n = 1'b1;
    tick();
    tick();

    // Positive sum: 1010 + 1000
    run_pair(32'd1010, 32'd1000, 32'h0000_07DA, 1'b0);

    // Negative sum: -0x10002530 + -0x12637841
    run_pair(32'hEFFF_DAD0, 32'hED9C_87BF, 32'hDD9C_628F, 1'b0);

    // Overflow boundaries
`ifdef SIGNED_ACCUM_SAT_EN
    run_pair(32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1);
    run_pair(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
`else
    run_pair(32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1);
    run_pair(32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b1);
`endif

    // Stalls, backpressure, ignored starts in DONE; ovf must be cleared
    lit_sum   = 32'd33009;
    lit_ovf   = 1'b0;
    lit_armed = 1'b1;
    start_frame(8'd3);
    send(32'd263, 0);
    send(32'd5363, 2);
    send(32'd27383, 2);
    wait_valid();
    bus.out_ready = 1'b0;
    tick();
    bus.start = 1'b1;
    bus.len   = 8'd5;
    tick();
    bus.start = 1'b0;
    tick();
    bus.out_ready = 1'b1;
    bus.start     = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    bus.start     = 1'b0;
    lit_armed     = 1'b0;
    tick();
    tick();

    // Zero-length frame
    lit_sum   = 32'h0;
    lit_ovf   = 1'b0;
    lit_armed = 1'b1;
    start_frame(8'd0);
    finish_frame(1);

    // Reset in the middle of a frame, off the clock edge
    start_frame(8'd4);
    send(32'd11, 0);
    send(32'd22, 0);
    #2 rst_n = 1'b0;
    #5 rst_n = 1'b1;
    tick();
    tick();

    // Frame after reset
    lit_sum   = 32'd25263;
    lit_ovf   = 1'b0;
    lit_armed = 1'b1;
    start_frame(8'd1);
    send(32'd25263, 0);
    finish_frame(0);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
